// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: state encodings and default width.
package mult_pkg;

    localparam int MULT_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_DONE    = 2'b10,
        ST_ILLEGAL = 2'b11
    } mult_state_t;

endpackage

// File: rtl/shift_add_mult_dp.sv
// Shift-and-add datapath: operand magnitude registers, accumulating product and
// the final sign correction.
module shift_add_mult_dp
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 b_zero,
    output logic                 last_step
);

    logic [2*WIDTH-1:0] a_q;
    logic [WIDTH-1:0]   b_q;
    logic               neg_q;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] sum;

    // Negating the most negative value wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    always_comb begin
        mag_a     = (signed_mode && a[WIDTH-1]) ? -a : a;
        mag_b     = (signed_mode && b[WIDTH-1]) ? -b : b;
        b_zero    = (mag_b == '0);
        last_step = (b_q[WIDTH-1:1] == '0);
        sum       = product + (b_q[0] ? a_q : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            product <= '0;
        end else if (load) begin
            a_q     <= {{WIDTH{1'b0}}, mag_a};
            b_q     <= mag_b;
            neg_q   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            product <= '0;
        end else if (step) begin
            a_q     <= a_q << 1;
            b_q     <= b_q >> 1;
            product <= (last_step && neg_q) ? -sum : sum;
        end
    end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier with early termination on the multiplier's highest set bit.
//
// state   | meaning
// IDLE    | waiting for start; product holds the last result
// RUN     | one partial product accumulated per cycle
// DONE    | one-cycle result strobe, then back to IDLE
// ILLEGAL | unreachable encoding, recovers to IDLE
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           state
);

    mult_state_t state_q;
    mult_state_t state_d;
    logic        load;
    logic        step;
    logic        b_zero;
    logic        last_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = b_zero ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN:  state_d = last_step ? ST_DONE : ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
        done  = (state_q == ST_DONE);
        state = state_q;
    end

    assign load = (state_q == ST_IDLE) && start;
    assign step = (state_q == ST_RUN);

    shift_add_mult_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .step        (step),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .product     (product),
        .b_zero      (b_zero),
        .last_step   (last_step)
    );

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 a  input  WIDTH  multiplicand; sampled with start.
REQ-007 b  input  WIDTH  multiplier; sampled with start.
REQ-008 product  output  2*WIDTH  result register; holds last result until next accepted start.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 done  output  1  single-cycle pulse, high only in DONE.
REQ-011 state  output  2  current FSM state encoding.

Function
REQ-012 States: IDLE=2'b00, RUN=2'b01, DONE=2'b10; 2'b11 is illegal and SHALL go to IDLE on the next edge.
REQ-013 IDLE, start=1 at edge: load magnitude |a| into 2W-bit register A (zero-extended), |b| into W-bit register B, clear product, capture sign flag = signed_mode & (a[W-1] ^ b[W-1]).
REQ-014 Magnitude rule: signed_mode=1 and MSB set -> two's-complement negate into W bits, unsigned interpretation; -2^(W-1) yields 2^(W-1).
REQ-015 Transition from IDLE on accepted start: to RUN if |b| != 0, else directly to DONE with product=0.
REQ-016 RUN, each edge: if B[0]=1 then product <= product + A; A <= A<<1; B <= B>>1; 2W-bit add, no overflow possible.
REQ-017 RUN exits to DONE at the edge where the shifted B equals zero (early termination); RUN lasts exactly (index of highest set bit of |b|)+1 cycles, max WIDTH.
REQ-018 On the RUN->DONE edge, if sign flag=1 the final product SHALL be stored negated (2W-bit two's complement) in the same edge.
REQ-019 DONE lasts exactly one cycle (done=1, product valid), then IDLE unconditionally.
REQ-020 start asserted in RUN or DONE SHALL be ignored and not queued; a, b, signed_mode changes outside the accept edge SHALL not affect the result.
REQ-021 start held high continuously SHALL begin a new operation on the first IDLE cycle after DONE (back-to-back; one IDLE cycle between operations).
REQ-022 product SHALL remain stable from DONE until the next accepted start.
REQ-023 Latency: accept edge to done=1 = RUN cycles + 1; b=0 gives 1 cycle.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, product=0, A=0, B=0, sign flag=0, busy=0, done=0, regardless of clock.
REQ-025 Reset during RUN SHALL abort the operation with no done pulse; first start after rst_n deasserts is accepted normally.

Structure
REQ-026 State encodings and the WIDTH default SHALL live in shared package mult_pkg.
REQ-027 Datapath (A, B, product registers, adder, negation) SHALL be sub-module shift_add_mult_dp; FSM stays in shift_add_mult.
REQ-028 Outputs busy, done, state SHALL be decoded from the state register only (Moore).

Verification
REQ-029 WIDTH=8, unsigned, a=13, b=11 -> 4 RUN cycles, done on 5th cycle after accept, product=143.
REQ-030 WIDTH=8, signed, a=-128 (0x80), b=-128 -> product=16384 (0x4000), 8 RUN cycles; a=-3, b=5 -> product=0xFFF1 (-15) after 3 RUN cycles.
REQ-031 b=0, a=255 -> no RUN, done 1 cycle after accept, product=0; b=1, a=200 -> 1 RUN cycle, product=200.
REQ-032 Accept a=7, b=200; pulse start and change a, b in RUN -> ignored, product=1400; start held high -> next op starts after one IDLE cycle.
REQ-033 rst_n low mid-RUN (a=255, b=255, cycle 3) -> state=IDLE, product=0 asynchronously, no done; next op a=2, b=3 -> 6.
REQ-034 WIDTH=16 and WIDTH=4 random unsigned/signed sweep against reference model, including extremes 0, max, min-negative.
